// File: rtl/piece_drop.sv
// Falling-piece stage of the tetris datapath: spawns a piece, applies moves and
// gravity on a 4x8 board, locks it, and waits for the cleared board to return.
module piece_drop #(
  parameter int GRAVITY_TICKS = 4,
  parameter int SPAWN_COL     = 1
) (
  input  logic        clka,
  input  logic        restart_n,
  input  logic [1:0]  next_piece,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        drop,
  input  logic [31:0] board_in,
  input  logic        board_in_valid,
  output logic [31:0] board_out,
  output logic [31:0] locked_board,
  output logic        lock_valid,
  output logic [1:0]  curr_piece,
  output logic [2:0]  piece_row,
  output logic [1:0]  piece_col,
  output logic        error
);

  localparam int CW = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(GRAVITY_TICKS - 1);
  localparam logic [1:0] SPAWN_C = (SPAWN_COL > 3) ? 2'd3 : 2'(SPAWN_COL);

  typedef enum logic [2:0] {S_SPAWN, S_FALL, S_LOCK, S_WAIT, S_OVER} state_t;

  // Occupancy of a piece at (row,col); bits pushed past bit 31 fall away.
  function automatic logic [31:0] piece_mask(input logic [1:0] t,
                                             input logic [3:0] row,
                                             input logic [2:0] col);
    logic [31:0] base;
    case (t)
      2'b00:   base = 32'h0000_0001;
      2'b01:   base = 32'h0000_0003;
      2'b10:   base = 32'h0000_0011;
      default: base = 32'h0000_0033;
    endcase
    return base << (6'({row, 2'b00}) + 6'(col));
  endfunction

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_board, w_board_nxt;
  logic [31:0]   r_locked, w_locked_nxt;
  logic          r_lock_vld, w_lock_vld_nxt;
  logic          r_err, w_err_nxt;
  logic [1:0]    r_type, w_type_nxt;
  logic [2:0]    r_row, w_row_nxt;
  logic [1:0]    r_col, w_col_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic [1:0]  w_spawn_col;
  logic [31:0] w_spawn_mask, w_mask, w_mask_dn, w_mask_l, w_mask_r;
  logic [3:0]  w_h;
  logic [1:0]  w_col_max;
  logic        w_grav, w_can_down;

  always_comb begin
    w_spawn_col  = (next_piece[0] && SPAWN_C > 2'd2) ? 2'd2 : SPAWN_C;
    w_spawn_mask = piece_mask(next_piece, 4'd0, {1'b0, w_spawn_col});
    w_mask       = piece_mask(r_type, {1'b0, r_row}, {1'b0, r_col});
    w_mask_dn    = piece_mask(r_type, {1'b0, r_row} + 4'd1, {1'b0, r_col});
    w_mask_l     = piece_mask(r_type, {1'b0, r_row}, {1'b0, r_col} - 3'd1);
    w_mask_r     = piece_mask(r_type, {1'b0, r_row}, {1'b0, r_col} + 3'd1);
    w_h          = r_type[1] ? 4'd2 : 4'd1;
    w_col_max    = r_type[0] ? 2'd2 : 2'd3;
    w_grav       = (r_cnt == CNT_LAST) || drop;
    w_can_down   = (({1'b0, r_row} + w_h) <= 4'd7) && ((w_mask_dn & r_board) == 32'd0);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_board_nxt    = r_board;
    w_locked_nxt   = r_locked;
    w_lock_vld_nxt = 1'b0;
    w_err_nxt      = r_err;
    w_type_nxt     = r_type;
    w_row_nxt      = r_row;
    w_col_nxt      = r_col;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      S_SPAWN: begin
        w_type_nxt = next_piece;
        w_row_nxt  = 3'd0;
        w_col_nxt  = w_spawn_col;
        w_cnt_nxt  = '0;
        if ((w_spawn_mask & r_board) != 32'd0) begin
          w_state_nxt = S_OVER;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_FALL;
        end
      end
      S_FALL: begin
        if (w_grav) begin
          w_cnt_nxt = '0;
          if (w_can_down) begin
            w_row_nxt = r_row + 3'd1;
          end else begin
            // Merge now so lock_valid and locked_board line up in the LOCK cycle.
            w_locked_nxt   = r_board | w_mask;
            w_lock_vld_nxt = 1'b1;
            w_state_nxt    = S_LOCK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (move_left && !move_right && r_col != 2'd0 &&
              (w_mask_l & r_board) == 32'd0)
            w_col_nxt = r_col - 2'd1;
          else if (move_right && !move_left && r_col < w_col_max &&
                   (w_mask_r & r_board) == 32'd0)
            w_col_nxt = r_col + 2'd1;
        end
      end
      S_LOCK: begin
        w_board_nxt = r_locked;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (board_in_valid) begin
          w_board_nxt = board_in;
          w_state_nxt = S_SPAWN;
        end
      end
      S_OVER:  w_state_nxt = S_OVER;
      default: w_state_nxt = S_SPAWN;
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_state    <= S_SPAWN;
      r_board    <= '0;
      r_locked   <= '0;
      r_lock_vld <= 1'b0;
      r_err      <= 1'b0;
      r_type     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_board    <= w_board_nxt;
      r_locked   <= w_locked_nxt;
      r_lock_vld <= w_lock_vld_nxt;
      r_err      <= w_err_nxt;
      r_type     <= w_type_nxt;
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Piece stays visible through LOCK until the merged board takes over.
  assign board_out    = (r_state == S_FALL || r_state == S_LOCK) ? (r_board | w_mask) : r_board;
  assign locked_board = r_locked;
  assign lock_valid   = r_lock_vld;
  assign curr_piece   = r_type;
  assign piece_row    = r_row;
  assign piece_col    = r_col;
  assign error        = r_err;

endmodule

// File: tb/tb_piece_drop.sv
// Directed bench for piece_drop: lock results go through a scoreboard queue
// checked by an independent monitor; state/reset behaviour checked inline.
module tb_piece_drop;

  logic        clka = 1'b0;
  logic        restart_n;
  logic [1:0]  next_piece;
  logic        move_left, move_right, drop;
  logic [31:0] board_in;
  logic        board_in_valid;
  logic [31:0] board_out, locked_board;
  logic        lock_valid;
  logic [1:0]  curr_piece;
  logic [2:0]  piece_row;
  logic [1:0]  piece_col;
  logic        error;

  typedef struct packed {
    logic [31:0] b;
    logic [1:0]  p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  piece_drop #(.GRAVITY_TICKS(4), .SPAWN_COL(1)) dut (
    .clka(clka), .restart_n(restart_n), .next_piece(next_piece),
    .move_left(move_left), .move_right(move_right), .drop(drop),
    .board_in(board_in), .board_in_valid(board_in_valid),
    .board_out(board_out), .locked_board(locked_board), .lock_valid(lock_valid),
    .curr_piece(curr_piece), .piece_row(piece_row), .piece_col(piece_col),
    .error(error)
  );

  always #5 clka = ~clka;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every lock_valid pulse must match the oldest expectation.
  always @(negedge clka) begin
    if (restart_n && lock_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lock_unexpected: got board %h piece %0d, expected no lock",
                 locked_board, curr_piece);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("locked_board", locked_board, e.b);
        chk("curr_piece", {30'd0, curr_piece}, {30'd0, e.p});
      end
    end
  end

  task automatic wait_lock(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clka);
      n++;
    end while (!lock_valid && n < 200);
    if (!lock_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no lock_valid within 200 cycles, expected a lock", name);
    end
  endtask

  // Called at the LOCK-cycle negedge; presents the cleared board in WAIT_CLEAR.
  task automatic ret_board(input logic [31:0] b, input logic [1:0] np);
    @(negedge clka);
    board_in       = b;
    next_piece     = np;
    board_in_valid = 1'b1;
    @(negedge clka);
    board_in_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_board_out"}, board_out, 32'd0);
    chk({tag, "_locked_board"}, locked_board, 32'd0);
    chk({tag, "_lock_valid"}, {31'd0, lock_valid}, 32'd0);
    chk({tag, "_curr_piece"}, {30'd0, curr_piece}, 32'd0);
    chk({tag, "_piece_row"}, {29'd0, piece_row}, 32'd0);
    chk({tag, "_piece_col"}, {30'd0, piece_col}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    restart_n = 1'b0; next_piece = 2'b00; move_left = 1'b0; move_right = 1'b0;
    drop = 1'b0; board_in = 32'd0; board_in_valid = 1'b0;

    // Reset state, then single piece falling under gravity alone.
    @(negedge clka);
    chk_reset("rst0");
    exp_q.push_back('{b: 32'h2000_0000, p: 2'b00});
    restart_n = 1'b1;
    repeat (4) @(negedge clka);
    chk("grav_row0", {29'd0, piece_row}, 32'd0);
    chk("spawn_col", {30'd0, piece_col}, 32'd1);
    @(negedge clka);
    chk("grav_row1", {29'd0, piece_row}, 32'd1);
    wait_lock("single");

    // Square with drop held.
    exp_q.push_back('{b: 32'h6600_0000, p: 2'b11});
    drop = 1'b1;
    ret_board(32'd0, 2'b11);
    wait_lock("square");
    drop = 1'b0;

    // Moves: left, blocked left at wall, both together.
    exp_q.push_back('{b: 32'h1000_0000, p: 2'b00});
    ret_board(32'd0, 2'b00);
    @(negedge clka);
    chk("mv_start_col", {30'd0, piece_col}, 32'd1);
    move_left = 1'b1;
    @(negedge clka);
    chk("mv_left1", {30'd0, piece_col}, 32'd0);
    @(negedge clka);
    chk("mv_left_wall", {30'd0, piece_col}, 32'd0);
    move_right = 1'b1;
    @(negedge clka);
    chk("mv_both", {30'd0, piece_col}, 32'd0);
    move_left = 1'b0; move_right = 1'b0;
    drop = 1'b1;
    wait_lock("moves");
    drop = 1'b0;

    // Vertical bar landing on an occupied cell.
    exp_q.push_back('{b: 32'h2220_0000, p: 2'b10});
    ret_board(32'h2000_0000, 2'b10);
    drop = 1'b1;
    wait_lock("vbar");
    drop = 1'b0;

    // Spawn collision: game over, sticky, inputs ignored.
    ret_board(32'h0000_0002, 2'b00);
    @(negedge clka);
    chk("over_error", {31'd0, error}, 32'd1);
    chk("over_board", board_out, 32'h0000_0002);
    move_left = 1'b1; drop = 1'b1; board_in = 32'd0; board_in_valid = 1'b1;
    repeat (6) @(negedge clka);
    move_left = 1'b0; drop = 1'b0; board_in_valid = 1'b0;
    chk("over_sticky", {31'd0, error}, 32'd1);
    chk("over_board_kept", board_out, 32'h0000_0002);

    // Reset out of GAMEOVER, fresh square spawn.
    #2 restart_n = 1'b0;
    #1 chk_reset("rst_over");
    @(negedge clka);
    next_piece = 2'b11;
    restart_n = 1'b1;
    @(negedge clka);
    chk("sq_row", {29'd0, piece_row}, 32'd0);
    chk("sq_col", {30'd0, piece_col}, 32'd1);
    chk("sq_board_out", board_out, 32'h0000_0066);
    repeat (5) @(negedge clka);

    // Reset mid-FALL.
    #2 restart_n = 1'b0;
    #1 chk_reset("rst_fall");
    @(negedge clka);
    next_piece = 2'b00;
    restart_n = 1'b1;
    exp_q.push_back('{b: 32'h2000_0000, p: 2'b00});
    drop = 1'b1;
    wait_lock("after_rst");
    drop = 1'b0;

    // Reset mid-WAIT_CLEAR.
    @(negedge clka);
    #2 restart_n = 1'b0;
    #1 chk_reset("rst_wait");
    @(negedge clka);
    restart_n = 1'b1;
    @(negedge clka);
    chk("fresh_row", {29'd0, piece_row}, 32'd0);
    chk("fresh_board_out", board_out, 32'h0000_0002);
    chk("fresh_error", {31'd0, error}, 32'd0);
    repeat (3) @(negedge clka);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL locks_pending: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piece_drop.md
Name: piece_drop

Overview:
- Upstream stage of clear_redraw in the tetris datapath.
- Holds the settled 4-column x 8-row board and spawns the incoming piece at the top.
- Applies left/right moves and gravity, then locks the piece into the board and hands the merged board plus piece type to the clear stage.
- Waits for the cleared board to return, then spawns the next piece. Flags game-over when a spawn collides.

Parameters:
GRAVITY_TICKS, 4, clock cycles between automatic one-row descents (>=1)
SPAWN_COL, 1, left column of a newly spawned piece, clamped to 4-width

Ports:
clka  input  1  system clock, rising-edge
restart_n  input  1  asynchronous active-low reset
next_piece  input  2  type of the piece to spawn, sampled in SPAWN
move_left  input  1  shift falling piece one column left
move_right  input  1  shift falling piece one column right
drop  input  1  force a gravity step this cycle
board_in  input  32  cleared board returned by clear stage
board_in_valid  input  1  board_in valid; accepted only in WAIT_CLEAR
board_out  output  32  display board: settled board OR falling piece in FALL, else settled board
locked_board  output  32  settled board merged with locked piece
lock_valid  output  1  one-cycle pulse, locked_board and curr_piece valid
curr_piece  output  2  type of the active/locked piece
piece_row  output  3  top row of piece bounding box
piece_col  output  2  left column of piece bounding box
error  output  1  sticky game-over flag

Behaviour:
- Board bit map: bit 4r+c = row r, column c. Row 0 is top, row 7 is bottom.
- Shapes, as cells relative to (row,col):
  - 00 single: (0,0); w1 h1.
  - 01 horizontal bar: (0,0),(0,1); w2 h1.
  - 10 vertical bar: (0,0),(1,0); w1 h2.
  - 11 square: all four cells of the 2x2 box; w2 h2.
- Legal positions: col 0..4-w, row 0..8-h. Piece mask built combinationally from type/row/col.
- Async reset:
  - Outputs: board_out=0, locked_board=0, lock_valid=0, curr_piece=0, piece_row=0, piece_col=0, error=0.
  - Internal: settled board=0, gravity counter=0, state=SPAWN.
  - Reset in any state aborts the falling piece and any pending handshake.
- States:
  - SPAWN (1 cycle): latch next_piece; row=0; col=min(SPAWN_COL,4-w); counter=0. If mask AND board !=0 go GAMEOVER, else go FALL.
  - FALL: counter increments every cycle. A gravity event occurs when counter==GRAVITY_TICKS-1 or drop=1.
    - On gravity event: counter=0. If row+h<=7 and the mask one row down has no overlap, row++. Otherwise go LOCK.
    - Moves are ignored in any cycle with a gravity event.
    - Without a gravity event: move_left alone moves col-1 if col>0 and the shifted mask does not overlap; move_right alone moves col+1 if col<4-w and no overlap. A blocked move leaves col unchanged.
    - move_left and move_right together: no move.
  - LOCK (1 cycle): board <= board | mask; locked_board <= merged value; lock_valid=1 for exactly this cycle; curr_piece holds the type. Go WAIT_CLEAR.
  - WAIT_CLEAR: board_out = board, no piece. When board_in_valid=1, board <= board_in and go SPAWN. board_in_valid in any other state is ignored.
  - GAMEOVER: error=1, sticky. board_out = board. All inputs ignored until reset.
- Latency:
  - Spawn to first automatic descent: GRAVITY_TICKS cycles.
  - Blocked gravity event to lock_valid: 1 cycle.
  - board_in_valid to spawn evaluation: 1 cycle.
- No arithmetic wrap: row/col never leave the legal range.

Test Plan:
- Empty board, next_piece=00, GRAVITY_TICKS=4, no inputs -> piece descends rows 0..7 every 4 cycles; 8th gravity event locks; lock_valid pulses once with locked_board=32'h2000_0000, curr_piece=00.
- Empty board, next_piece=11, drop held -> one row per cycle; locks at rows 6-7 cols 1-2; locked_board=32'h6600_0000.
- Piece 00 at col 1, move_left twice between gravity events -> col 0 after first, stays 0 after second; then move_left+move_right together -> col unchanged; lock gives locked_board=32'h1000_0000.
- After lock, return board_in=32'h0000_0002 with board_in_valid, next_piece=00 -> SPAWN collides at row0 col1; error=1 and stays 1; later moves and board_in_valid have no effect.
- Piece 10 falling onto board with bit 29 set (row7 col1), col 1 -> locks at rows 5-6; locked_board=32'h2220_0000.
- Assert restart_n low mid-FALL and mid-WAIT_CLEAR -> all outputs 0 immediately; after release a fresh spawn occurs at row 0 with empty board.
